// File: rtl/dbfs_mul_share_arbiter_if.sv
// Bundles the request, multiplier and response channels of the shared dBFS multiplier.
// The slave modport is the arbiter's view; the master modport is the view of requesters, multiplier and consumer.
interface dbfs_mul_share_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 1,
   parameter int A_W     = 38,
   parameter int B_W     = 4,
   parameter int P_W     = 42
);
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic                   mul_ce;
   logic [A_W-1:0]         mul_din0;
   logic [B_W-1:0]         mul_din1;
   logic [P_W-1:0]         mul_dout;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [P_W-1:0]         rsp_data;
   logic [2:0]             inflight;

   modport slave (
      input  req_valid, req_a, req_b, mul_dout, rsp_ready,
      output req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, inflight
   );

   modport master (
      output req_valid, req_a, req_b, mul_dout, rsp_ready,
      input  req_ready, mul_ce, mul_din0, mul_din1, rsp_valid, rsp_id, rsp_data, inflight
   );
endinterface

// File: rtl/dbfs_mul_share_arbiter.sv
// Round-robin sharing of one clock-enabled pipelined multiplier; requester IDs ride alongside
// the multiplier stages, and response backpressure freezes the whole pipe through mul_ce.
module dbfs_mul_share_arbiter #(
   parameter int NUM_REQ     = 2,
   parameter int ID_W        = 1,
   parameter int A_W         = 38,
   parameter int B_W         = 4,
   parameter int P_W         = 42,
   parameter int MUL_LATENCY = 1
) (
   input logic                   clk,
   input logic                   reset,
   dbfs_mul_share_arbiter_if.slave bus
);

   logic                   mulCe;
   logic                   grantAny;
   logic [ID_W-1:0]        grantIdx;
   logic [NUM_REQ-1:0]     grant;
   logic [A_W-1:0]         din0;
   logic [B_W-1:0]         din1;
   logic [ID_W-1:0]        rrPtr_q, rrPtr_d;
   logic [MUL_LATENCY-1:0] vldPipe_q, vldPipe_d;
   logic [ID_W-1:0]        idPipe_q [MUL_LATENCY];
   logic [ID_W-1:0]        idPipe_d [MUL_LATENCY];
   logic [2:0]             inflightCnt;

   // The clock enable stays high in reset so stale multiplier contents are flushed.
   always_comb begin
      mulCe = !reset || !vldPipe_q[MUL_LATENCY-1] || bus.rsp_ready;
   end

   always_comb begin
      int cand;
      cand     = 0;
      grantAny = 1'b0;
      grantIdx = '0;
      grant    = '0;
      din0     = '0;
      din1     = '0;
      if (reset && mulCe) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rrPtr_q) + k;
            if (cand >= NUM_REQ) begin
               cand = cand - NUM_REQ;
            end
            for (int r = 0; r < NUM_REQ; r++) begin
               if (!grantAny && (r == cand) && bus.req_valid[r]) begin
                  grantAny = 1'b1;
                  grantIdx = ID_W'(r);
                  grant[r] = 1'b1;
                  din0     = bus.req_a[r*A_W +: A_W];
                  din1     = bus.req_b[r*B_W +: B_W];
               end
            end
         end
      end
   end

   always_comb begin
      rrPtr_d = rrPtr_q;
      if (grantAny) begin
         rrPtr_d = (int'(grantIdx) == NUM_REQ - 1) ? '0 : grantIdx + ID_W'(1);
      end
   end

   // ID/valid shadow of the multiplier stages; they hold whenever the multiplier holds.
   always_comb begin
      vldPipe_d = vldPipe_q;
      for (int k = 0; k < MUL_LATENCY; k++) begin
         idPipe_d[k] = idPipe_q[k];
      end
      if (mulCe) begin
         vldPipe_d[0] = grantAny;
         idPipe_d[0]  = grantIdx;
         for (int k = 1; k < MUL_LATENCY; k++) begin
            vldPipe_d[k] = vldPipe_q[k-1];
            idPipe_d[k]  = idPipe_q[k-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rrPtr_q   <= '0;
         vldPipe_q <= '0;
         for (int k = 0; k < MUL_LATENCY; k++) begin
            idPipe_q[k] <= '0;
         end
      end else begin
         rrPtr_q   <= rrPtr_d;
         vldPipe_q <= vldPipe_d;
         for (int k = 0; k < MUL_LATENCY; k++) begin
            idPipe_q[k] <= idPipe_d[k];
         end
      end
   end

   always_comb begin
      inflightCnt = '0;
      for (int k = 0; k < MUL_LATENCY; k++) begin
         inflightCnt = inflightCnt + {2'b00, vldPipe_q[k]};
      end
   end

   assign bus.req_ready = grant;
   assign bus.mul_ce    = mulCe;
   assign bus.mul_din0  = din0;
   assign bus.mul_din1  = din1;
   assign bus.rsp_valid = vldPipe_q[MUL_LATENCY-1];
   assign bus.rsp_id    = idPipe_q[MUL_LATENCY-1];
   assign bus.rsp_data  = bus.mul_dout;
   assign bus.inflight  = inflightCnt;

endmodule

// File: tb/tb_dbfs_mul_share_arbiter.sv
// Directed bench: a latency-1 instance covers arbitration, max operands and reset,
// and a latency-2 instance covers response backpressure.
module tb_dbfs_mul_share_arbiter;

   localparam int A_W = 38;
   localparam int B_W = 4;
   localparam int P_W = 42;

   logic clk = 1'b0;
   logic rstN;
   int   nAsserts = 0;
   int   nFails   = 0;

   logic [P_W-1:0] mul1Q;
   logic [P_W-1:0] mul2S0, mul2S1;

   dbfs_mul_share_arbiter_if #(.NUM_REQ(2), .ID_W(1), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus1 ();
   dbfs_mul_share_arbiter_if #(.NUM_REQ(2), .ID_W(1), .A_W(A_W), .B_W(B_W), .P_W(P_W)) bus2 ();

   dbfs_mul_share_arbiter #(.NUM_REQ(2), .ID_W(1), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LATENCY(1)) u1 (
      .clk   (clk),
      .reset (rstN),
      .bus   (bus1.slave)
   );

   dbfs_mul_share_arbiter #(.NUM_REQ(2), .ID_W(1), .A_W(A_W), .B_W(B_W), .P_W(P_W), .MUL_LATENCY(2)) u2 (
      .clk   (clk),
      .reset (rstN),
      .bus   (bus2.slave)
   );

   always #5 clk = ~clk;

   // Behavioural clock-enabled multipliers standing in for the real IP.
   always_ff @(posedge clk) begin
      if (bus1.mul_ce) begin
         mul1Q <= P_W'(bus1.mul_din0) * P_W'(bus1.mul_din1);
      end
   end
   assign bus1.mul_dout = mul1Q;

   always_ff @(posedge clk) begin
      if (bus2.mul_ce) begin
         mul2S0 <= P_W'(bus2.mul_din0) * P_W'(bus2.mul_din1);
         mul2S1 <= mul2S0;
      end
   end
   assign bus2.mul_dout = mul2S1;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit second, input logic [1:0] valid,
                                input logic [A_W-1:0] a0, input logic [B_W-1:0] b0,
                                input logic [A_W-1:0] a1, input logic [B_W-1:0] b1,
                                input logic rdy);
      if (second) begin
         bus2.req_valid = valid;
         bus2.req_a     = {a1, a0};
         bus2.req_b     = {b1, b0};
         bus2.rsp_ready = rdy;
      end else begin
         bus1.req_valid = valid;
         bus1.req_a     = {a1, a0};
         bus1.req_b     = {b1, b0};
         bus1.rsp_ready = rdy;
      end
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nAsserts++;
      assert (observed === expected) else begin
         nFails++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      rstN = 1'b0;
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1);
      applyStimulus(1'b1, 2'b00, '0, '0, '0, '0, 1'b1);
      tick();
      tick();
      checkOutput("rst_rsp_valid1", 64'(bus1.rsp_valid), 64'd0);
      checkOutput("rst_inflight1",  64'(bus1.inflight),  64'd0);
      checkOutput("rst_req_ready1", 64'(bus1.req_ready), 64'd0);
      checkOutput("rst_mul_ce1",    64'(bus1.mul_ce),    64'd1);
      checkOutput("rst_rsp_valid2", 64'(bus2.rsp_valid), 64'd0);
      checkOutput("rst_inflight2",  64'(bus2.inflight),  64'd0);
      rstN = 1'b1;

      // Single request 1000*7
      applyStimulus(1'b0, 2'b01, 38'd1000, 4'd7, '0, '0, 1'b1);
      checkOutput("t1_req_ready", 64'(bus1.req_ready), 64'b01);
      checkOutput("t1_din0",      64'(bus1.mul_din0),  64'd1000);
      checkOutput("t1_din1",      64'(bus1.mul_din1),  64'd7);
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1);
      checkOutput("t1_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
      checkOutput("t1_rsp_id",    64'(bus1.rsp_id),    64'd0);
      checkOutput("t1_rsp_data",  64'(bus1.rsp_data),  64'd7000);
      checkOutput("t1_inflight",  64'(bus1.inflight),  64'd1);

      // Requester 1 alone, which brings the pointer back to 0
      applyStimulus(1'b0, 2'b10, '0, '0, 38'd5, 4'd5, 1'b1);
      checkOutput("r1_req_ready", 64'(bus1.req_ready), 64'b10);
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1);
      checkOutput("r1_rsp_id",   64'(bus1.rsp_id),   64'd1);
      checkOutput("r1_rsp_data", 64'(bus1.rsp_data), 64'd25);

      // Contention: 10*2=20 for requester 0, 20*3=60 for requester 1
      for (int c = 0; c < 6; c++) begin
         applyStimulus(1'b0, 2'b11, 38'd10, 4'd2, 38'd20, 4'd3, 1'b1);
         checkOutput("t2_req_ready", 64'(bus1.req_ready), (c % 2 == 0) ? 64'b01 : 64'b10);
         tick();
         #1;
         checkOutput("t2_rsp_valid", 64'(bus1.rsp_valid), 64'd1);
         checkOutput("t2_rsp_id",    64'(bus1.rsp_id),    64'(c % 2));
         checkOutput("t2_rsp_data",  64'(bus1.rsp_data),  (c % 2 == 0) ? 64'd20 : 64'd60);
      end
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1);
      tick();
      #1;
      checkOutput("bubble_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
      checkOutput("bubble_inflight",  64'(bus1.inflight),  64'd0);

      // Maximum operands, then accept and issue in the same cycle
      applyStimulus(1'b0, 2'b01, {A_W{1'b1}}, 4'd15, '0, '0, 1'b1);
      checkOutput("t4_req_ready", 64'(bus1.req_ready), 64'b01);
      tick();
      applyStimulus(1'b0, 2'b10, '0, '0, 38'd3, 4'd11, 1'b1);
      checkOutput("t4_rsp_data",  64'(bus1.rsp_data),  64'h3BFFFFFFFF1);
      checkOutput("t4_rsp_id",    64'(bus1.rsp_id),    64'd0);
      checkOutput("t6_req_ready", 64'(bus1.req_ready), 64'b10);
      checkOutput("t6_mul_ce",    64'(bus1.mul_ce),    64'd1);
      tick();
      applyStimulus(1'b0, 2'b01, 38'd4, 4'd4, '0, '0, 1'b1);
      checkOutput("t6_rsp_id",    64'(bus1.rsp_id),    64'd1);
      checkOutput("t6_rsp_data",  64'(bus1.rsp_data),  64'd33);
      checkOutput("t6_req_ready", 64'(bus1.req_ready), 64'b01);
      tick();

      // Reset while one product is in flight and the pointer sits at 1
      rstN = 1'b0;
      applyStimulus(1'b0, 2'b11, 38'd6, 4'd1, 38'd9, 4'd1, 1'b1);
      checkOutput("t5_pre_inflight", 64'(bus1.inflight),  64'd1);
      checkOutput("t5_pre_data",     64'(bus1.rsp_data),  64'd16);
      checkOutput("t5_rst_ready",    64'(bus1.req_ready), 64'b00);
      checkOutput("t5_rst_mul_ce",   64'(bus1.mul_ce),    64'd1);
      tick();
      rstN = 1'b1;
      #1;
      checkOutput("t5_rsp_valid", 64'(bus1.rsp_valid), 64'd0);
      checkOutput("t5_inflight",  64'(bus1.inflight),  64'd0);
      checkOutput("t5_req_ready", 64'(bus1.req_ready), 64'b01);
      tick();
      applyStimulus(1'b0, 2'b00, '0, '0, '0, '0, 1'b1);
      checkOutput("t5_rsp_id",   64'(bus1.rsp_id),   64'd0);
      checkOutput("t5_rsp_data", 64'(bus1.rsp_data), 64'd6);

      // Backpressure on the latency-2 instance: 100*2=200, 300*3=900
      applyStimulus(1'b1, 2'b11, 38'd100, 4'd2, 38'd300, 4'd3, 1'b1);
      checkOutput("t3_ready0", 64'(bus2.req_ready), 64'b01);
      tick();
      #1;
      checkOutput("t3_ready1",    64'(bus2.req_ready), 64'b10);
      checkOutput("t3_inflight1", 64'(bus2.inflight),  64'd1);
      checkOutput("t3_no_rsp",    64'(bus2.rsp_valid), 64'd0);
      tick();
      for (int s = 0; s < 3; s++) begin
         applyStimulus(1'b1, 2'b11, 38'd100, 4'd2, 38'd300, 4'd3, 1'b0);
         checkOutput("t3_stall_ce",    64'(bus2.mul_ce),    64'd0);
         checkOutput("t3_stall_ready", 64'(bus2.req_ready), 64'b00);
         checkOutput("t3_stall_valid", 64'(bus2.rsp_valid), 64'd1);
         checkOutput("t3_stall_id",    64'(bus2.rsp_id),    64'd0);
         checkOutput("t3_stall_data",  64'(bus2.rsp_data),  64'd200);
         checkOutput("t3_stall_infl",  64'(bus2.inflight),  64'd2);
         tick();
      end
      applyStimulus(1'b1, 2'b00, '0, '0, '0, '0, 1'b1);
      checkOutput("t3_rel_ce",   64'(bus2.mul_ce),   64'd1);
      checkOutput("t3_rel_id",   64'(bus2.rsp_id),   64'd0);
      checkOutput("t3_rel_data", 64'(bus2.rsp_data), 64'd200);
      tick();
      #1;
      checkOutput("t3_drain_valid", 64'(bus2.rsp_valid), 64'd1);
      checkOutput("t3_drain_id",    64'(bus2.rsp_id),    64'd1);
      checkOutput("t3_drain_data",  64'(bus2.rsp_data),  64'd900);
      checkOutput("t3_drain_infl",  64'(bus2.inflight),  64'd1);
      tick();
      #1;
      checkOutput("t3_empty_valid", 64'(bus2.rsp_valid), 64'd0);
      checkOutput("t3_empty_infl",  64'(bus2.inflight),  64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule

// File: doc/dbfs_mul_share_arbiter.md
Name: dbfs_mul_share_arbiter

Overview:
Shares one pipelined unsigned multiplier (38-bit x 4-bit -> 42-bit, clock-enabled) between NUM_REQ requesters in the dBFS converter datapath.
- Arbitrates requests round-robin and drives the multiplier operands and clock enable.
- Tracks requester IDs through the multiplier latency and returns each product on a shared response channel tagged with the requester ID.
- Backpressure on the response channel freezes the whole multiplier pipeline through its clock enable.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ID_W, 1, requester-ID width, equal to ceil(log2(NUM_REQ)) and at least 1
A_W, 38, operand A width (multiplier din0)
B_W, 4, operand B width (multiplier din1)
P_W, 42, product width (multiplier dout)
MUL_LATENCY, 1, register stages inside the multiplier (1..4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_a  in  NUM_REQ*A_W  packed operand A; requester i uses bits [i*A_W +: A_W]
req_b  in  NUM_REQ*B_W  packed operand B; requester i uses bits [i*B_W +: B_W]
mul_ce  out  1  multiplier clock enable
mul_din0  out  A_W  multiplier operand A
mul_din1  out  B_W  multiplier operand B
mul_dout  in  P_W  multiplier product
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  ID_W  requester ID of the current response
rsp_data  out  P_W  product; wired directly from mul_dout
inflight  out  3  number of valid pipeline slots (0..MUL_LATENCY)

Behaviour:
- Reset: sampled at a clk edge with reset==0. Clears vld_pipe[0..L-1] and id_pipe, and sets rr_ptr=0.
  - rsp_valid=0 and inflight=0 from the first edge with reset low.
  - req_ready=0 while reset is low.
  - mul_ce=1 during reset, so stale multiplier contents are flushed.
- Reset mid-operation: in-flight products are discarded with no response. Requesters must re-present their requests.
- Advance: mul_ce = ~rsp_valid | rsp_ready (combinational).
  - A response is transferred when rsp_valid & rsp_ready.
- Arbitration (combinational, only when mul_ce=1 and reset=1):
  - Search requesters starting at rr_ptr, ascending with wrap at NUM_REQ-1 -> 0.
  - The first i with req_valid[i]=1 receives req_ready[i]=1.
  - When mul_ce=0, req_ready is all-zero.
- Transfer: req_valid[i] & req_ready[i] at an edge.
  - Then rr_ptr <= (i+1) mod NUM_REQ.
  - Without a grant, rr_ptr holds.
- Operand mux: mul_din0/mul_din1 = operands of the granted requester; all zeros when nothing is granted.
- Pipeline (updates only on edges with mul_ce=1):
  - vld_pipe[0] <= grant_any; id_pipe[0] <= granted index.
  - Stage k <= stage k-1.
  - With mul_ce=0 all stages hold, matching the multiplier's held registers.
- Response outputs:
  - rsp_valid = vld_pipe[L-1]; rsp_id = id_pipe[L-1]; rsp_data = mul_dout.
  - Latency from grant edge to rsp_valid is exactly MUL_LATENCY cycles with no stall.
- Throughput: one issue per cycle when rsp_ready stays high.
- Bubbles: a bubble (no grant) propagates as an invalid slot and does not stall.
- rsp_data under stall: stays stable while rsp_valid=1 and rsp_ready=0.
- inflight: popcount of vld_pipe.
- Simultaneous events in the same cycle:
  - Response accept plus new grant: both occur, and the pipeline shifts.
  - Stall plus pending requests: no grant is made, and rr_ptr holds.
- Requester protocol: a requester may deassert req_valid before its grant with no effect. Operands must be stable while req_valid=1 and not yet granted.
- Width rule: rsp_data is the full unsigned product of zero-extended operands, with no truncation. The maximum product (2^38-1)*15 fits in 42 bits.

Test Plan:
1. Single request, L=1: requester 0 presents a=1000, b=7 with rsp_ready=1. Required: req_ready[0]=1 in that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=7000.
2. Contention fairness: both requesters hold valid for 6 cycles with rsp_ready=1. Required: grants alternate 0,1,0,1,0,1; responses arrive in the same order with correct IDs.
3. Backpressure, L=2: issue back-to-back, then drop rsp_ready for 3 cycles. Required: mul_ce=0, req_ready=0, rsp_data/rsp_id held, inflight=2; on release, results drain in order with nothing lost or duplicated.
4. Maximum operands: a=2^38-1, b=15. Required: rsp_data = 4123168604145 (0x3BFFFFFFFF1).
5. Reset mid-flight: assert reset low for 1 cycle while inflight=1. Required: next cycle rsp_valid=0, inflight=0, rr_ptr=0; the first request after reset goes to requester 0 when both are valid.
6. Simultaneous accept and issue: rsp_valid=1 and rsp_ready=1 while requester 1 is valid. Required: grant in the same cycle; the next response is requester 1's product after MUL_LATENCY cycles.
